// File: rtl/l1d_cache_pkg.sv
// l1d_cache_pkg -- shared definitions for the L1 data cache.
//   state_t       : controller states (IDLE=0, REFILL=1, WRITE=2)
//   BEAT_READ/BEAT_WRITE : values driven on mem_we
//   BYTE_OFFSET_BITS     : byte-within-word address bits
//   merge_bytes()        : byte-enable merge of a store into a word
package l1d_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  localparam logic BEAT_READ  = 1'b0;
  localparam logic BEAT_WRITE = 1'b1;

  localparam int BYTE_OFFSET_BITS = 2;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/l1d_line_array.sv
// l1d_line_array -- valid/tag/data storage for the direct-mapped L1D.
// All accesses target the single line selected by 'index'.
//   clock, reset        : clock, async active-high reset (clears valid bits only)
//   index, rd_word      : line and word selected for combinational read
//   rd_valid/rd_tag/rd_data : combinational read of the selected line/word
//   word_we, wr_word, wr_data, wr_be : synchronous byte-enabled word write
//   tag_we, wr_tag      : synchronous tag write that also sets the valid bit
module l1d_line_array
  import l1d_cache_pkg::*;
#(
  parameter int INDEX_BITS       = 6,
  parameter int OFFSET_WORD_BITS = 2,
  parameter int TAG_BITS         = 22
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [INDEX_BITS-1:0]       index,
  input  logic [OFFSET_WORD_BITS-1:0] rd_word,
  output logic                        rd_valid,
  output logic [TAG_BITS-1:0]         rd_tag,
  output logic [31:0]                 rd_data,
  input  logic                        word_we,
  input  logic [OFFSET_WORD_BITS-1:0] wr_word,
  input  logic [31:0]                 wr_data,
  input  logic [3:0]                  wr_be,
  input  logic                        tag_we,
  input  logic [TAG_BITS-1:0]         wr_tag
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam int WORDS = 2 ** OFFSET_WORD_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES*WORDS];

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_mem[index];
  assign rd_data  = data_mem[{index, rd_word}];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone define
  // cache contents, which keeps these mappable onto plain RAM.
  always_ff @(posedge clock) begin
    if (tag_we) tag_mem[index] <= wr_tag;
    if (word_we) begin
      data_mem[{index, wr_word}] <= merge_bytes(data_mem[{index, wr_word}], wr_data, wr_be);
    end
  end

endmodule

// File: rtl/l1d_cache.sv
// l1d_cache -- direct-mapped, write-through, no-write-allocate L1 data cache.
// Read hits are served combinationally; read misses stall and refill a full
// line (ascending from word 0); every store is a single bus write beat, and a
// store hit also merges into the cached word.
// Optional feature macro: L1D_PERF_CNT_EN adds perf_hits / perf_misses.
// Ports:
//   clock, reset                     : clock, async active-high reset
//   cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_be : MEM-stage request (held while stalled)
//   cpu_rdata, cpu_stall             : load data, pipeline stall
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be : bus beat request
//   mem_ack, mem_rdata               : bus beat completion and read data
//   perf_hits, perf_misses           : (L1D_PERF_CNT_EN only) event counters
module l1d_cache
  import l1d_cache_pkg::*;
#(
  parameter int INDEX_BITS       = 6,
  parameter int OFFSET_WORD_BITS = 2,
  parameter int ADDR_BITS        = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_be,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_be,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata
`ifdef L1D_PERF_CNT_EN
  ,
  output logic [31:0]          perf_hits,
  output logic [31:0]          perf_misses
`endif
);

  localparam int TAG_LSB  = INDEX_BITS + OFFSET_WORD_BITS + BYTE_OFFSET_BITS;
  localparam int TAG_BITS = ADDR_BITS - TAG_LSB;

  logic [TAG_BITS-1:0]         addr_tag;
  logic [INDEX_BITS-1:0]       addr_index;
  logic [OFFSET_WORD_BITS-1:0] addr_word;

  assign addr_tag   = cpu_addr[ADDR_BITS-1:TAG_LSB];
  assign addr_index = cpu_addr[TAG_LSB-1 -: INDEX_BITS];
  assign addr_word  = cpu_addr[BYTE_OFFSET_BITS +: OFFSET_WORD_BITS];

  state_t                      state_q, state_d;
  logic [OFFSET_WORD_BITS-1:0] beat_q, beat_d;

  logic                        line_valid;
  logic [TAG_BITS-1:0]         line_tag;
  logic [31:0]                 line_data;
  logic                        hit;

  logic                        word_we;
  logic [OFFSET_WORD_BITS-1:0] wr_word;
  logic [31:0]                 wr_data;
  logic [3:0]                  wr_be;
  logic                        tag_we;

  // Requests are masked while reset is held so the stall and bus outputs sit
  // at their reset values even if the CPU keeps a request up.
  logic req_write, req_read;
  assign req_write = cpu_wr & ~reset;
  assign req_read  = cpu_rd & ~cpu_wr & ~reset;

  assign hit = line_valid && (line_tag == addr_tag);

  l1d_line_array #(
    .INDEX_BITS      (INDEX_BITS),
    .OFFSET_WORD_BITS(OFFSET_WORD_BITS),
    .TAG_BITS        (TAG_BITS)
  ) u_lines (
    .clock   (clock),
    .reset   (reset),
    .index   (addr_index),
    .rd_word (addr_word),
    .rd_valid(line_valid),
    .rd_tag  (line_tag),
    .rd_data (line_data),
    .word_we (word_we),
    .wr_word (wr_word),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .tag_we  (tag_we),
    .wr_tag  (addr_tag)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = BEAT_READ;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    word_we   = 1'b0;
    wr_word   = addr_word;
    wr_data   = cpu_wdata;
    wr_be     = cpu_be;
    tag_we    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_write) begin
          cpu_stall = 1'b1;
          state_d   = ST_WRITE;
        end else if (req_read) begin
          if (hit) begin
            cpu_rdata = line_data;
          end else begin
            cpu_stall = 1'b1;
            beat_d    = '0;
            state_d   = ST_REFILL;
          end
        end
      end

      ST_REFILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {addr_tag, addr_index, beat_q, 2'b00};
        if (mem_ack) begin
          word_we = 1'b1;
          wr_word = beat_q;
          wr_data = mem_rdata;
          wr_be   = 4'hF;
          beat_d  = beat_q + OFFSET_WORD_BITS'(1);
          if (beat_q == '1) begin
            tag_we  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_WRITE: begin
        // The stall drops in the ack cycle so the store retires at this edge.
        cpu_stall = ~mem_ack;
        mem_req   = 1'b1;
        mem_we    = BEAT_WRITE;
        mem_addr  = cpu_addr & ~ADDR_BITS'(3);
        mem_wdata = cpu_wdata;
        mem_be    = cpu_be;
        if (mem_ack) begin
          word_we = hit;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

`ifdef L1D_PERF_CNT_EN
  logic read_hit, refill_start;
  assign read_hit     = (state_q == ST_IDLE) && req_read && hit;
  assign refill_start = (state_q == ST_IDLE) && req_read && !hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (read_hit)     perf_hits   <= perf_hits + 32'd1;
      if (refill_start) perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1d_cache.sv
// tb_l1d_cache -- scoreboard bench for l1d_cache.
// The driver issues one CPU request at a time; a reference model derives the
// expected bus beats, stall length and load data from the cache rules and a
// flat word memory, and pushes them onto queues. A bus responder acks beats
// after a chosen delay; a monitor pops and compares whenever the DUT presents
// a bus beat or completes a CPU request.
module tb_l1d_cache;

  localparam int WPL   = 4;
  localparam int LINES = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef L1D_PERF_CNT_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  always #5 clock = ~clock;

  l1d_cache dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_be   (cpu_be),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
`ifdef L1D_PERF_CNT_EN
    ,
    .perf_hits  (perf_hits),
    .perf_misses(perf_misses)
`endif
  );

  typedef struct {
    logic        is_write;
    logic [31:0] rdata;
    int          stalls;
  } cpu_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  cpu_exp_t    exp_q[$];
  beat_t       beat_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          ack_delay = 0;
  int          exp_hits = 0;
  int          exp_misses = 0;

  logic [31:0] ref_mem [int unsigned];
  logic        m_valid [LINES];
  logic [21:0] m_tag   [LINES];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int unsigned key;
    key = a >> 2;
    if (ref_mem.exists(key)) return ref_mem[key];
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Reference model: one request, derived from the cache rules.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int delay);
    cpu_exp_t    e;
    beat_t       b;
    int          idx;
    logic [21:0] tg;
    logic [31:0] merged;
    idx = int'(addr[9:4]);
    tg  = addr[31:10];
    if (wr) begin
      b.we = 1'b1; b.addr = {addr[31:2], 2'b00}; b.wdata = wdata; b.be = be;
      beat_q.push_back(b);
      merged = mem_word(addr);
      for (int k = 0; k < 4; k++) if (be[k]) merged[8*k +: 8] = wdata[8*k +: 8];
      ref_mem[addr >> 2] = merged;
      e.is_write = 1'b1; e.rdata = '0; e.stalls = 1 + delay;
      exp_q.push_back(e);
    end else if (rd) begin
      e.is_write = 1'b0;
      e.stalls   = 0;
      if (!(m_valid[idx] && m_tag[idx] == tg)) begin
        for (int w = 0; w < WPL; w++) begin
          b.we = 1'b0; b.addr = {addr[31:4], 4'b0000} + 32'(4 * w); b.wdata = '0; b.be = '0;
          beat_q.push_back(b);
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        e.stalls     = 1 + WPL * (delay + 1);
        exp_misses++;
      end
      exp_hits++;
      e.rdata = mem_word(addr);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int delay);
    int start;
    @(negedge clock);
    ack_delay = delay;
    issue(rd, wr, addr, wdata, be, delay);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    start = done_cnt;
    for (int i = 0; i < 200; i++) begin
      #3;
      if (done_cnt != start) break;
      @(negedge clock);
    end
    check("op_done", 32'(done_cnt), 32'(start + 1));
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = $urandom;
  endtask

  // Bus responder: acks a beat after ack_delay wait cycles; read data comes
  // from the reference memory, junk otherwise.
  initial begin : responder
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req && !reset) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (!mem_we) mem_rdata = mem_word(mem_addr);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compares bus beats and completed CPU requests against the queues.
  initial begin : monitor
    int       stall_cnt;
    cpu_exp_t e;
    beat_t    b;
    stall_cnt = 0;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        stall_cnt = 0;
      end else begin
        if (mem_req) begin
          if (beat_q.size() == 0) begin
            check("beat_expected", 32'(beat_q.size()), 32'd1);
          end else begin
            b = beat_q[0];
            check("beat_we", 32'(mem_we), 32'(b.we));
            check("beat_addr", mem_addr, b.addr);
            if (b.we) begin
              check("beat_wdata", mem_wdata, b.wdata);
              check("beat_be", 32'(mem_be), 32'(b.be));
            end
            if (mem_ack) void'(beat_q.pop_front());
          end
        end else begin
          check("bus_idle_addr", mem_addr, 32'd0);
          check("bus_idle_wdata", mem_wdata, 32'd0);
          check("bus_idle_be", 32'(mem_be), 32'd0);
        end

        if (cpu_rd || cpu_wr) begin
          if (cpu_stall) begin
            stall_cnt++;
          end else begin
            if (exp_q.size() == 0) begin
              check("resp_expected", 32'(exp_q.size()), 32'd1);
            end else begin
              e = exp_q.pop_front();
              check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
              if (!e.is_write) check("rdata", cpu_rdata, e.rdata);
            end
            stall_cnt = 0;
            done_cnt++;
          end
        end else begin
          check("idle_stall", 32'(cpu_stall), 32'd0);
          check("idle_rdata", cpu_rdata, 32'd0);
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] a;
    int          r;
    reset = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    #2;
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Cold line fill, then hit on another word of the same line.
    ref_mem[32'h40 >> 2] = 32'h11;
    ref_mem[32'h44 >> 2] = 32'h22;
    ref_mem[32'h48 >> 2] = 32'h33;
    ref_mem[32'h4C >> 2] = 32'h44;
    do_op(1'b1, 1'b0, 32'h0000_0040, '0, '0, 0);
    do_op(1'b1, 1'b0, 32'h0000_0048, '0, '0, 0);

    // Partial store hit, then reread.
    do_op(1'b0, 1'b1, 32'h0000_0044, 32'hAABB_CCDD, 4'b0011, 0);
    do_op(1'b1, 1'b0, 32'h0000_0044, '0, '0, 0);
    for (int w = 0; w < WPL; w++) ref_mem[(32'hC0 >> 2) + w] = '0;
    do_op(1'b1, 1'b0, 32'h0000_00C4, '0, '0, 0);
    do_op(1'b0, 1'b1, 32'h0000_00C4, 32'hAABB_CCDD, 4'b0011, 1);
    do_op(1'b1, 1'b0, 32'h0000_00C4, '0, '0, 0);

    // Write miss allocates nothing.
    do_op(1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 1);
    do_op(1'b1, 1'b0, 32'h0000_1000, '0, '0, 0);

    // Conflict on index 4.
    do_op(1'b1, 1'b0, 32'h0000_0040, '0, '0, 0);
    do_op(1'b1, 1'b0, 32'h0000_0440, '0, '0, 0);
    do_op(1'b1, 1'b0, 32'h0000_0040, '0, '0, 0);

    // Slow bus: three wait cycles per beat.
    do_op(1'b1, 1'b0, 32'h0000_0800, '0, '0, 3);
    do_op(1'b0, 1'b1, 32'h0000_0804, 32'h1234_5678, 4'b1100, 3);
    do_op(1'b1, 1'b0, 32'h0000_0804, '0, '0, 0);

    // Simultaneous rd and wr is a store.
    do_op(1'b1, 1'b1, 32'h0000_0808, 32'hCAFE_F00D, 4'b1010, 0);
    do_op(1'b1, 1'b0, 32'h0000_0808, '0, '0, 0);

    // Reset while beat 2 of a refill is on the bus.
    @(negedge clock);
    ack_delay = 0;
    issue(1'b1, 1'b0, 32'h0000_2000, '0, '0, 0);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_2000;
    repeat (3) @(negedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("reset_drops_req", 32'(mem_req), 32'd0);
    check("reset_drops_stall", 32'(cpu_stall), 32'd0);
    exp_q.delete();
    beat_q.delete();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    cpu_rd = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    do_op(1'b1, 1'b0, 32'h0000_2000, '0, '0, 0);
    do_op(1'b1, 1'b0, 32'h0000_0040, '0, '0, 0);

    // Randomized traffic over four tags so hits, misses and conflicts mix.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 255) << 2);
      if (r == 0)      idle_cycle();
      else if (r <= 5) do_op(1'b1, 1'b0, a, '0, '0, $urandom_range(0, 2));
      else if (r <= 8) do_op(1'b0, 1'b1, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      else             do_op(1'b1, 1'b1, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end
    idle_cycle();
    repeat (2) @(negedge clock);
    #3;
    check("beats_left", 32'(beat_q.size()), 32'd0);
    check("resps_left", 32'(exp_q.size()), 32'd0);
`ifdef L1D_PERF_CNT_EN
    check("perf_hits", perf_hits, 32'(exp_hits));
    check("perf_misses", perf_misses, 32'(exp_misses));
`endif
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
